// File: rtl/ps2_keyboard_handler.sv
// PS/2 keyboard front end: deserialises device frames into scan-code bytes,
// buffers them in a small FIFO and decodes make/break sequences into the
// currently held key plus a running key-press count.
module ps2_keyboard_handler #(
  parameter int unsigned FIFO_AW    = 3,
  parameter logic [7:0]  BREAK_CODE = 8'hF0,
  parameter logic [7:0]  EXT_CODE   = 8'hE0
) (
  input  logic       clk,
  input  logic       clrn,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic [7:0] key,
  output logic [7:0] cnt,
  output logic [7:0] data,
  output logic       ready,
  output logic       overflow
);

  localparam int unsigned Depth = 1 << FIFO_AW;

  // Receiver state
  logic [2:0] ps2_clk_sync;
  logic [3:0] bit_cnt;
  logic [9:0] frame_buf;
  logic       sample;
  logic       frame_done;
  logic       frame_ok;

  // FIFO state
  logic [7:0]         fifo [Depth];
  logic [FIFO_AW-1:0] w_ptr;
  logic [FIFO_AW-1:0] r_ptr;
  logic [FIFO_AW-1:0] w_ptr_inc;
  logic [FIFO_AW-1:0] r_ptr_inc;
  logic               full;
  logic               push;
  logic               pop;
  logic               nextdata_n;

  // Decoder state
  logic brk;

  // Bring the asynchronous PS/2 clock into the clk domain.
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      ps2_clk_sync <= 3'b000;
    end else begin
      ps2_clk_sync <= {ps2_clk_sync[1:0], ps2_clk};
    end
  end

  // Falling edge: older stage high, newer stage low.
  assign sample     = ps2_clk_sync[2] & ~ps2_clk_sync[1];
  assign frame_done = sample && (bit_cnt == 4'd10);
  // Stop bit is the live ps2_data sample on the 11th edge; odd parity over data+parity.
  assign frame_ok   = frame_done && !frame_buf[0] && ps2_data && (^frame_buf[9:1]);

  // Shift in bits 0..9 of the frame; the 11th edge only closes the frame.
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      bit_cnt   <= 4'd0;
      frame_buf <= 10'd0;
    end else if (sample) begin
      if (bit_cnt == 4'd10) begin
        bit_cnt <= 4'd0;
      end else begin
        frame_buf[bit_cnt] <= ps2_data;
        bit_cnt            <= bit_cnt + 4'd1;
      end
    end
  end

  assign w_ptr_inc  = w_ptr + 1'b1;
  assign r_ptr_inc  = r_ptr + 1'b1;
  // One slot is always left empty so that full and empty are distinguishable.
  assign full       = (w_ptr_inc == r_ptr);
  assign ready      = (w_ptr != r_ptr);
  assign data       = fifo[r_ptr];
  assign push       = frame_ok;
  // The decoder takes a byte every cycle one is available.
  assign nextdata_n = ~ready;
  assign pop        = ready & ~nextdata_n;

  // FIFO storage, pointers and sticky overflow flag.
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      w_ptr    <= '0;
      r_ptr    <= '0;
      overflow <= 1'b0;
      for (int unsigned i = 0; i < Depth; i++) begin
        fifo[i] <= 8'h00;
      end
    end else begin
      if (push) begin
        if (full) begin
          overflow <= 1'b1;
        end else begin
          fifo[w_ptr] <= frame_buf[8:1];
          w_ptr       <= w_ptr_inc;
        end
      end
      if (pop) begin
        r_ptr <= r_ptr_inc;
      end
    end
  end

  // Make/break decoder: consumes the head byte in the cycle it is popped.
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      key <= 8'h00;
      cnt <= 8'h00;
      brk <= 1'b0;
    end else if (pop) begin
      if (data == BREAK_CODE) begin
        brk <= 1'b1;
      end else if (data == EXT_CODE) begin
        brk <= brk;
      end else if (brk) begin
        if (data == key) begin
          key <= 8'h00;
        end
        brk <= 1'b0;
      end else if (data != key) begin
        // Repeats of the held key (typematic) are not new presses.
        key <= data;
        cnt <= cnt + 8'd1;
      end
    end
  end

endmodule

// File: tb/tb_ps2_keyboard_handler.sv
// Self-checking bench for ps2_keyboard_handler: directed scenarios plus a
// randomized make/break stream checked against a keyboard-level reference model.
module tb_ps2_keyboard_handler;

  localparam int Half = 6;  // clk cycles per PS/2 clock phase
  localparam int Idle = 4;  // clk cycles of idle line after each frame
  localparam int Cap  = 7;  // usable FIFO slots: full when w_ptr+1 == r_ptr

  logic       clk = 1'b0;
  logic       clrn;
  logic       ps2_clk;
  logic       ps2_data;
  logic [7:0] key;
  logic [7:0] cnt;
  logic [7:0] data;
  logic       ready;
  logic       overflow;

  int vectors = 0;
  int errors  = 0;
  int ready_cycles = 0;

  // Reference model: which key is held, how many presses, pending release.
  logic [7:0] m_key;
  logic [7:0] m_cnt;
  bit         m_brk;

  ps2_keyboard_handler dut (
    .clk      (clk),
    .clrn     (clrn),
    .ps2_clk  (ps2_clk),
    .ps2_data (ps2_data),
    .key      (key),
    .cnt      (cnt),
    .data     (data),
    .ready    (ready),
    .overflow (overflow)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (ready === 1'b1) ready_cycles++;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  function automatic void model_reset();
    m_key = 8'h00;
    m_cnt = 8'h00;
    m_brk = 1'b0;
  endfunction

  function automatic void model_byte(input logic [7:0] b);
    if (b == 8'hF0) begin
      m_brk = 1'b1;
    end else if (b == 8'hE0) begin
      m_brk = m_brk;
    end else if (m_brk) begin
      if (b == m_key) m_key = 8'h00;
      m_brk = 1'b0;
    end else if (b != m_key) begin
      m_key = b;
      m_cnt = m_cnt + 8'd1;
    end
  endfunction

  task automatic send_frame(input logic [7:0] d, input bit bad_par, input bit bad_stop);
    logic [10:0] bits;
    bits = {~bad_stop, (~^d) ^ bad_par, d, 1'b0};
    for (int i = 0; i < 11; i++) begin
      @(posedge clk); #1 ps2_data = bits[i];
      repeat (Half) @(posedge clk);
      #1 ps2_clk = 1'b0;
      repeat (Half) @(posedge clk);
      #1 ps2_clk = 1'b1;
    end
    ps2_data = 1'b1;
    repeat (Idle) @(posedge clk);
    @(negedge clk);
  endtask

  task automatic apply_reset();
    clrn = 1'b0;
    ps2_clk = 1'b1;
    ps2_data = 1'b1;
    repeat (3) @(posedge clk);
    #1 clrn = 1'b1;
    model_reset();
    repeat (3) @(posedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset();
    clrn = 1'b0;
    ps2_clk = 1'b1;
    ps2_data = 1'b1;
    repeat (2) @(negedge clk);
    vectors++; if (key !== 8'h00) begin errors++; $display("FAIL reset_key: got %h want 00", key); end
    vectors++; if (cnt !== 8'h00) begin errors++; $display("FAIL reset_cnt: got %h want 00", cnt); end
    vectors++; if (data !== 8'h00) begin errors++; $display("FAIL reset_data: got %h want 00", data); end
    vectors++; if (ready !== 1'b0) begin errors++; $display("FAIL reset_ready: got %b want 0", ready); end
    vectors++;
    if (overflow !== 1'b0) begin errors++; $display("FAIL reset_overflow: got %b want 0", overflow); end
    apply_reset();
  endtask

  task automatic test_make_break();
    logic [7:0] seq [4] = '{8'h1C, 8'h45, 8'hF0, 8'h45};
    apply_reset();
    for (int i = 0; i < 4; i++) begin
      send_frame(seq[i], 1'b0, 1'b0);
      model_byte(seq[i]);
      vectors++;
      if (key !== m_key) begin errors++; $display("FAIL mb_key[%0d]: got %h want %h", i, key, m_key); end
      vectors++;
      if (cnt !== m_cnt) begin errors++; $display("FAIL mb_cnt[%0d]: got %h want %h", i, cnt, m_cnt); end
      vectors++;
      if (ready !== 1'b0) begin errors++; $display("FAIL mb_ready[%0d]: got %b want 0", i, ready); end
      vectors++;
      if (overflow !== 1'b0) begin errors++; $display("FAIL mb_ovf[%0d]: got %b want 0", i, overflow); end
    end
  endtask

  task automatic test_typematic();
    logic [7:0] seq [6] = '{8'h1C, 8'h1C, 8'h1C, 8'hF0, 8'h1C, 8'h32};
    apply_reset();
    for (int i = 0; i < 6; i++) begin
      send_frame(seq[i], 1'b0, 1'b0);
      model_byte(seq[i]);
      vectors++;
      if (key !== m_key) begin errors++; $display("FAIL typ_key[%0d]: got %h want %h", i, key, m_key); end
      vectors++;
      if (cnt !== m_cnt) begin errors++; $display("FAIL typ_cnt[%0d]: got %h want %h", i, cnt, m_cnt); end
    end
  endtask

  task automatic test_bad_frames();
    apply_reset();
    ready_cycles = 0;
    send_frame(8'h1C, 1'b1, 1'b0);
    send_frame(8'h1C, 1'b0, 1'b1);
    vectors++; if (key !== 8'h00) begin errors++; $display("FAIL bad_key: got %h want 00", key); end
    vectors++; if (cnt !== 8'h00) begin errors++; $display("FAIL bad_cnt: got %h want 00", cnt); end
    vectors++;
    if (ready_cycles !== 0) begin
      errors++; $display("FAIL bad_ready: got %0d ready cycles want 0", ready_cycles);
    end
    // Receiver must still frame correctly after the rejected frames.
    send_frame(8'h2B, 1'b0, 1'b0);
    vectors++; if (key !== 8'h2B) begin errors++; $display("FAIL bad_after_key: got %h want 2B", key); end
  endtask

  task automatic test_overflow();
    logic [7:0] sent [9];
    logic [7:0] got [$];
    apply_reset();
    force dut.nextdata_n = 1'b1;
    for (int i = 0; i < 9; i++) begin
      sent[i] = 8'($urandom_range(1, 255));
      send_frame(sent[i], 1'b0, 1'b0);
    end
    vectors++; if (overflow !== 1'b1) begin errors++; $display("FAIL ovf_flag: got %b want 1", overflow); end
    vectors++; if (ready !== 1'b1) begin errors++; $display("FAIL ovf_ready: got %b want 1", ready); end
    vectors++; if (data !== sent[0]) begin errors++; $display("FAIL ovf_head: got %h want %h", data, sent[0]); end
    release dut.nextdata_n;
    for (int i = 0; i < 20; i++) begin
      #1;
      if (ready === 1'b1) got.push_back(data);
      @(negedge clk);
    end
    vectors++;
    if (got.size() != Cap) begin
      errors++; $display("FAIL ovf_count: got %0d bytes want %0d", got.size(), Cap);
    end
    for (int i = 0; i < Cap && i < got.size(); i++) begin
      vectors++;
      if (got[i] !== sent[i]) begin
        errors++; $display("FAIL ovf_order[%0d]: got %h want %h", i, got[i], sent[i]);
      end
    end
    for (int i = 0; i < Cap; i++) model_byte(sent[i]);
    vectors++; if (key !== m_key) begin errors++; $display("FAIL ovf_key: got %h want %h", key, m_key); end
    vectors++; if (cnt !== m_cnt) begin errors++; $display("FAIL ovf_cnt: got %h want %h", cnt, m_cnt); end
    send_frame(8'h1C, 1'b0, 1'b0);
    vectors++;
    if (overflow !== 1'b1) begin errors++; $display("FAIL ovf_sticky: got %b want 1", overflow); end
    apply_reset();
    vectors++;
    if (overflow !== 1'b0) begin errors++; $display("FAIL ovf_clear: got %b want 0", overflow); end
  endtask

  task automatic test_reset_mid_frame();
    logic [10:0] bits;
    apply_reset();
    bits = {1'b1, ~^8'hAA, 8'hAA, 1'b0};
    // Start bit plus data bits 0..4, then reset during the high phase.
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1 ps2_data = bits[i];
      repeat (Half) @(posedge clk);
      #1 ps2_clk = 1'b0;
      repeat (Half) @(posedge clk);
      #1 ps2_clk = 1'b1;
    end
    repeat (2) @(posedge clk);
    apply_reset();
    ready_cycles = 0;
    send_frame(8'h32, 1'b0, 1'b0);
    vectors++; if (key !== 8'h32) begin errors++; $display("FAIL mid_key: got %h want 32", key); end
    vectors++; if (cnt !== 8'h01) begin errors++; $display("FAIL mid_cnt: got %h want 01", cnt); end
    vectors++;
    if (ready_cycles !== 1) begin
      errors++; $display("FAIL mid_stray: got %0d ready cycles want 1", ready_cycles);
    end
  endtask

  task automatic test_random();
    logic [7:0] pool [6] = '{8'h1C, 8'h32, 8'h45, 8'h1B, 8'h23, 8'h2B};
    logic [7:0] seq [$];
    apply_reset();
    for (int n = 0; n < 40; n++) begin
      int act;
      act = int'($urandom_range(0, 9));
      seq.delete();
      if (act <= 5) begin
        seq.push_back(pool[$urandom_range(0, 5)]);
      end else if (act <= 7) begin
        seq.push_back(8'hF0);
        seq.push_back(pool[$urandom_range(0, 5)]);
      end else if (act == 8) begin
        seq.push_back(8'hE0);
        seq.push_back(pool[$urandom_range(0, 5)]);
      end else begin
        seq.push_back(8'hF0);
        seq.push_back((m_key == 8'h00) ? pool[0] : m_key);
      end
      foreach (seq[j]) begin
        send_frame(seq[j], 1'b0, 1'b0);
        model_byte(seq[j]);
        vectors++;
        if (key !== m_key) begin errors++; $display("FAIL rnd_key[%0d]: got %h want %h", n, key, m_key); end
        vectors++;
        if (cnt !== m_cnt) begin errors++; $display("FAIL rnd_cnt[%0d]: got %h want %h", n, cnt, m_cnt); end
      end
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_make_break();
    test_typematic();
    test_bad_frames();
    test_overflow();
    test_reset_mid_frame();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
